// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep checker: walks every input assignment through a combinational
// Skolem netlist and accumulates the spec verdict, fail count and first counterexample.
module skolem_sweep_checker #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 2,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  x_vec,
    input  logic [N_OUT-1:0] y_vec,
    input  logic             spec_sat,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             cex_valid,
    output logic [N_IN-1:0]  cex_x,
    output logic [N_OUT-1:0] cex_y
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    localparam logic [N_IN-1:0] X_LAST = '1;

    state_t             state;
    logic               smp_valid;
    logic [N_IN-1:0]    smp_x;
    logic [N_OUT-1:0]   smp_y;
    logic               smp_sat;
    logic               smp_fail;
    logic [CNT_W-1:0]   fail_next;

    // fail_next is the count including the sample being accumulated this edge,
    // so the DRAIN edge can derive pass from the final total.
    always_comb begin
        smp_fail  = smp_valid && !smp_sat;
        fail_next = fail_cnt + CNT_W'(smp_fail);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_vec     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_cnt  <= '0;
            cex_valid <= 1'b0;
            cex_x     <= '0;
            cex_y     <= '0;
            smp_valid <= 1'b0;
            smp_x     <= '0;
            smp_y     <= '0;
            smp_sat   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Accumulate stage; an abort discards the pending sample.
            if (smp_fail && !abort) begin
                fail_cnt <= fail_next;
                if (!cex_valid) begin
                    cex_valid <= 1'b1;
                    cex_x     <= smp_x;
                    cex_y     <= smp_y;
                end
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= SWEEP;
                        busy      <= 1'b1;
                        x_vec     <= '0;
                        fail_cnt  <= '0;
                        pass      <= 1'b0;
                        cex_valid <= 1'b0;
                        cex_x     <= '0;
                        cex_y     <= '0;
                        smp_valid <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        pass      <= 1'b0;
                        smp_valid <= 1'b0;
                    end else begin
                        smp_valid <= 1'b1;
                        smp_x     <= x_vec;
                        smp_y     <= y_vec;
                        smp_sat   <= spec_sat;
                        if (x_vec == X_LAST) begin
                            state <= DRAIN;
                        end else begin
                            x_vec <= x_vec + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    smp_valid <= 1'b0;
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        done <= 1'b1;
                        pass <= (fail_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench for skolem_sweep_checker with a tiny Skolem/spec stub driven by mode.
module tb_skolem_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [5:0] x_vec;
    logic [1:0] y_vec;
    logic       spec_sat;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] fail_cnt;
    logic       cex_valid;
    logic [5:0] cex_x;
    logic [1:0] cex_y;

    logic [1:0] mode;
    int         n_checks = 0;
    int         n_fail   = 0;

    skolem_sweep_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_vec(x_vec), .y_vec(y_vec), .spec_sat(spec_sat),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .cex_valid(cex_valid), .cex_x(cex_x), .cex_y(cex_y)
    );

    always #5 clk = ~clk;

    // Stub Skolem netlist (y = x[1:0]) and spec evaluator selected by mode
    always_comb begin
        y_vec = x_vec[1:0];
        case (mode)
            2'd0:    spec_sat = 1'b1;
            2'd1:    spec_sat = !((x_vec == 6'h2A) || (x_vec == 6'h3F));
            default: spec_sat = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        tick();
        tick();
        n_checks++;
        if ({x_vec, busy, done, pass, fail_cnt, cex_valid, cex_x, cex_y} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got x=%h busy=%b done=%b pass=%b fc=%h cv=%b cx=%h cy=%h, want all 0",
                     x_vec, busy, done, pass, fail_cnt, cex_valid, cex_x, cex_y);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_full_sweep();
        logic [5:0] exp_x;
        int         bad_walk = 0;
        mode = 2'd0;
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || x_vec !== 6'd0) begin
            n_fail++;
            $display("[TB] FAIL sweep_e0: got busy=%b x=%h want busy=1 x=00", busy, x_vec);
        end
        for (int k = 1; k <= 64; k++) begin
            tick();
            exp_x = (k > 63) ? 6'd63 : 6'(k);
            if (x_vec !== exp_x || busy !== 1'b1 || done !== 1'b0) begin
                bad_walk++;
                $display("[TB] FAIL sweep_walk E%0d: got x=%h busy=%b done=%b want x=%h busy=1 done=0",
                         k, x_vec, busy, done, exp_x);
            end
        end
        n_checks++;
        if (bad_walk != 0) n_fail++;
        tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || fail_cnt !== 7'd0 || cex_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sweep_e65: got done=%b busy=%b pass=%b fc=%h cv=%b want 1 0 1 00 0",
                     done, busy, pass, fail_cnt, cex_valid);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || pass !== 1'b1 || x_vec !== 6'h3F) begin
            n_fail++;
            $display("[TB] FAIL sweep_after: got done=%b pass=%b x=%h want 0 1 3f", done, pass, x_vec);
        end
    endtask

    task automatic test_two_failures();
        mode = 2'd1;
        pulse_start();
        repeat (65) tick();
        n_checks++;
        if (done !== 1'b1 || fail_cnt !== 7'd2 || pass !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL two_fail_count: got done=%b fc=%h pass=%b want 1 02 0", done, fail_cnt, pass);
        end
        n_checks++;
        if (cex_valid !== 1'b1 || cex_x !== 6'h2A || cex_y !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL two_fail_cex: got cv=%b cx=%h cy=%b want 1 2a 10", cex_valid, cex_x, cex_y);
        end
    endtask

    task automatic test_all_fail();
        int n_done = 0;
        int done_at = -1;
        mode = 2'd2;
        pulse_start();
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                done_at = k;
            end
            if (k == 65) begin
                n_checks++;
                if (fail_cnt !== 7'h40 || cex_valid !== 1'b1 || cex_x !== 6'h00 || cex_y !== 2'b00 || pass !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL all_fail_result: got fc=%h cv=%b cx=%h cy=%b pass=%b want 40 1 00 00 0",
                             fail_cnt, cex_valid, cex_x, cex_y, pass);
                end
            end
        end
        n_checks++;
        if (n_done != 1 || done_at != 65) begin
            n_fail++;
            $display("[TB] FAIL all_fail_done: got %0d pulses at E%0d want 1 at E65", n_done, done_at);
        end
    endtask

    task automatic test_abort();
        int n_done = 0;
        mode = 2'd0;
        pulse_start();
        repeat (10) tick();
        n_checks++;
        if (x_vec !== 6'd10) begin
            n_fail++;
            $display("[TB] FAIL abort_pre_x: got %h want 0a", x_vec);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_state: got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
        end
        for (int k = 0; k < 70; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: got %0d pulses busy=%b want 0 0", n_done, busy);
        end
        pulse_start();
        repeat (65) tick();
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || fail_cnt !== 7'd0 || cex_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_restart: got done=%b pass=%b fc=%h cv=%b want 1 1 00 0",
                     done, pass, fail_cnt, cex_valid);
        end
        tick();
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || x_vec !== 6'h3F || pass !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_abort_idle: got busy=%b x=%h pass=%b want 0 3f 1", busy, x_vec, pass);
        end
    endtask

    task automatic test_back_to_back();
        int done_at = -1;
        mode = 2'd0;
        pulse_start();
        for (int k = 1; k <= 70; k++) begin
            if (k == 5 || k == 20 || k == 40 || k == 64) start = 1'b1;
            tick();
            start = 1'b0;
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        n_checks++;
        if (done_at != 65) begin
            n_fail++;
            $display("[TB] FAIL start_while_busy: got done at E%0d want E65", done_at);
        end
    endtask

    task automatic test_reset_mid_sweep();
        mode = 2'd1;
        pulse_start();
        repeat (32) tick();
        n_checks++;
        if (x_vec !== 6'h20 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_pre: got x=%h busy=%b want 20 1", x_vec, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({x_vec, busy, done, pass, fail_cnt, cex_valid, cex_x, cex_y} !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_async: got x=%h busy=%b pass=%b fc=%h cv=%b cx=%h want all 0",
                     x_vec, busy, pass, fail_cnt, cex_valid, cex_x);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0 || x_vec !== 6'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_idle: got busy=%b x=%h want 0 00", busy, x_vec);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_two_failures();
        test_all_fail();
        test_abort();
        test_start_abort_idle();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
